// File: rtl/ssm_buf_ctrl.sv
// rtl/ssm_buf_ctrl.sv - packet ring-buffer controller for the ssm packet RAM
//
// Writes 134-bit packet words from dmux into a simple dual-port RAM used as a
// circular buffer, commits or rolls back each packet on its valid strobe,
// queues per-packet descriptors and replays committed packets to mux.
//
// Optional feature macro: SSM_BUF_STAT_EN (replay packet/word statistics).
//
// Ports:
//   clk, rst        single clock; asynchronous active-high reset
//   in_data         packet word, [133:132] = 01 head, 11 body, 10 tail
//   in_data_wr      in_data qualifier
//   in_valid        packet good (1) / bad (0), qualified by in_valid_wr
//   in_valid_wr     one pulse per packet, in the tail cycle or later
//   out_data        replayed packet word (RAM read data, 0 when not qualified)
//   out_data_wr     out_data qualifier
//   out_valid       1 whenever out_valid_wr is 1
//   out_valid_wr    one pulse the cycle after the last out_data_wr of a packet
//   out_alf         downstream almost full, sampled only at packet start
//   ram_wr_addr/ram_wr_data/ram_wr   RAM port A
//   ram_rd_addr/ram_rd               RAM port B; read data valid next cycle
//   ram_rd_data     RAM port B read data (doutb)
//   drop_cnt        dropped packets, saturating
//   stat_pkt_cnt    replayed packets (0 unless SSM_BUF_STAT_EN)
//   stat_word_cnt   replayed words   (0 unless SSM_BUF_STAT_EN)

module ssm_buf_ctrl #(
    parameter int ADDR_W       = 11,
    parameter int DESC_DEPTH_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [133:0]      in_data,
    input  logic              in_data_wr,
    input  logic              in_valid,
    input  logic              in_valid_wr,
    output logic [133:0]      out_data,
    output logic              out_data_wr,
    output logic              out_valid,
    output logic              out_valid_wr,
    input  logic              out_alf,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [133:0]      ram_wr_data,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic              ram_rd,
    input  logic [133:0]      ram_rd_data,
    output logic [31:0]       drop_cnt,
    output logic [31:0]       stat_pkt_cnt,
    output logic [31:0]       stat_word_cnt
);

    localparam int PTR_W      = ADDR_W + 1;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int DESC_DEPTH = 1 << DESC_DEPTH_W;

    typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, TAIL} state_t;

    state_t                  state, state_next;
    logic [PTR_W-1:0]        wr_ptr, pkt_start, rel_ptr, used;
    logic                    drop;
    logic                    buf_full, is_head, drop_now, drop_next, wr_en;
    logic [PTR_W-1:0]        pkt_start_cur, wr_ptr_inc, pkt_len;
    logic                    commit_ok, push, rollback, pop;

    logic [ADDR_W-1:0]       desc_start [DESC_DEPTH];
    logic [PTR_W-1:0]        desc_len   [DESC_DEPTH];
    logic [DESC_DEPTH_W-1:0] desc_widx, desc_ridx;
    logic [DESC_DEPTH_W:0]   desc_cnt;
    logic                    desc_full, desc_empty;

    logic [ADDR_W-1:0]       rd_addr;
    logic [PTR_W-1:0]        rd_left, cur_len;
    logic                    rd_dly;

    // Write side: the wrap bit makes used == DEPTH distinguishable from empty.
    assign used      = wr_ptr - rel_ptr;
    assign buf_full  = (used == PTR_W'(DEPTH));
    assign is_head   = in_data_wr && (in_data[133:132] == 2'b01);
    // A head word starts a fresh packet, so it sees the drop flag as clear.
    assign drop_now  = is_head ? 1'b0 : drop;
    assign wr_en     = in_data_wr && !buf_full && !drop_now && !rst;
    assign drop_next = drop_now || (in_data_wr && buf_full);

    assign pkt_start_cur = is_head ? wr_ptr : pkt_start;
    // Length includes a tail word written in the same cycle as the strobe.
    assign wr_ptr_inc    = wr_ptr + PTR_W'(wr_en);
    assign pkt_len       = wr_ptr_inc - pkt_start_cur;

    assign desc_full  = (desc_cnt == (DESC_DEPTH_W+1)'(DESC_DEPTH));
    assign desc_empty = (desc_cnt == '0);

    assign commit_ok = in_valid && !drop_next && !desc_full;
    // A good strobe with nothing written carries no data and is ignored.
    assign push      = in_valid_wr && commit_ok && (pkt_len != '0);
    assign rollback  = in_valid_wr && !commit_ok;
    assign pop       = (state == LOAD);

    assign ram_wr      = wr_en;
    assign ram_wr_addr = wr_en ? wr_ptr[ADDR_W-1:0] : '0;
    assign ram_wr_data = wr_en ? in_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            pkt_start <= '0;
            drop      <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            drop <= drop_next;
            if (rollback) begin
                wr_ptr    <= pkt_start_cur;
                pkt_start <= pkt_start_cur;
                if (drop_cnt != 32'hFFFF_FFFF)
                    drop_cnt <= drop_cnt + 32'd1;
            end else begin
                wr_ptr <= wr_ptr_inc;
                // After a commit, headless words must not reach back into
                // the committed packet if they are later rolled back.
                pkt_start <= (in_valid_wr && commit_ok) ? wr_ptr_inc : pkt_start_cur;
            end
        end
    end

    // Descriptor FIFO storage needs no reset; occupancy is tracked by desc_cnt.
    always_ff @(posedge clk) begin
        if (push) begin
            desc_start[desc_widx] <= pkt_start_cur[ADDR_W-1:0];
            desc_len[desc_widx]   <= pkt_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            desc_widx <= '0;
            desc_ridx <= '0;
            desc_cnt  <= '0;
        end else begin
            if (push) desc_widx <= desc_widx + 1'b1;
            if (pop)  desc_ridx <= desc_ridx + 1'b1;
            case ({push, pop})
                2'b10:   desc_cnt <= desc_cnt + 1'b1;
                2'b01:   desc_cnt <= desc_cnt - 1'b1;
                default: desc_cnt <= desc_cnt;
            endcase
        end
    end

    // Read FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_addr <= '0;
            rd_left <= '0;
            cur_len <= '0;
            rel_ptr <= '0;
            rd_dly  <= 1'b0;
        end else begin
            state  <= state_next;
            rd_dly <= ram_rd;
            case (state)
                LOAD: begin
                    rd_addr <= desc_start[desc_ridx];
                    rd_left <= desc_len[desc_ridx];
                    cur_len <= desc_len[desc_ridx];
                end
                READ: begin
                    rd_addr <= rd_addr + 1'b1;
                    rd_left <= rd_left - 1'b1;
                end
                TAIL:    rel_ptr <= rel_ptr + cur_len;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        ram_rd       = 1'b0;
        out_valid_wr = 1'b0;
        case (state)
            IDLE:  if (!desc_empty && !out_alf) state_next = LOAD;
            LOAD:  state_next = READ;
            READ: begin
                ram_rd = 1'b1;
                if (rd_left == PTR_W'(1)) state_next = DRAIN;
            end
            DRAIN: state_next = TAIL;
            TAIL: begin
                out_valid_wr = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ram_rd_addr = ram_rd ? rd_addr : '0;
    assign out_data_wr = rd_dly;
    assign out_data    = rd_dly ? ram_rd_data : '0;
    assign out_valid   = out_valid_wr;

`ifdef SSM_BUF_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkt_cnt  <= '0;
            stat_word_cnt <= '0;
        end else begin
            if (out_valid_wr) stat_pkt_cnt  <= stat_pkt_cnt + 32'd1;
            if (out_data_wr)  stat_word_cnt <= stat_word_cnt + 32'd1;
        end
    end
`else
    assign stat_pkt_cnt  = '0;
    assign stat_word_cnt = '0;
`endif

endmodule

// File: tb/tb_ssm_buf_ctrl.sv
// tb/tb_ssm_buf_ctrl.sv - self-checking bench for ssm_buf_ctrl

module tb_ssm_buf_ctrl;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [133:0]      in_data;
    logic              in_data_wr, in_valid, in_valid_wr;
    logic [133:0]      out_data;
    logic              out_data_wr, out_valid, out_valid_wr, out_alf;
    logic [ADDR_W-1:0] ram_wr_addr, ram_rd_addr;
    logic [133:0]      ram_wr_data, ram_rd_data;
    logic              ram_wr, ram_rd;
    logic [31:0]       drop_cnt, stat_pkt_cnt, stat_word_cnt;

    always #5 clk = ~clk;

    ssm_buf_ctrl #(.ADDR_W(ADDR_W), .DESC_DEPTH_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_data_wr(in_data_wr),
        .in_valid(in_valid), .in_valid_wr(in_valid_wr),
        .out_data(out_data), .out_data_wr(out_data_wr),
        .out_valid(out_valid), .out_valid_wr(out_valid_wr),
        .out_alf(out_alf),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wr(ram_wr),
        .ram_rd_addr(ram_rd_addr), .ram_rd(ram_rd), .ram_rd_data(ram_rd_data),
        .drop_cnt(drop_cnt), .stat_pkt_cnt(stat_pkt_cnt), .stat_word_cnt(stat_word_cnt)
    );

    // Packet RAM model
    logic [133:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wr) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd) ram_rd_data <= mem[ram_rd_addr];
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event expected but not seen / unexpected event", name);
    endtask

    // Scoreboard: expected words and packet lengths pushed by the driver
    logic [133:0] exp_q [$];
    int           len_q [$];
    int           cur_words = 0;
    int           first_cyc = -1;
    int           rd_seen = 0, vwr_seen = 0, words_seen = 0;
    logic [133:0] mon_e;
    int           mon_l;

    always @(negedge clk) begin
        if (rst) begin
            cur_words  = 0;
            vwr_seen   = 0;
            words_seen = 0;
        end else begin
            if (ram_rd) rd_seen++;
            if (cur_words > 0 && !out_valid_wr) check("no_bubble", out_data_wr, 1);
            if (out_data_wr) begin
                if (cur_words == 0) first_cyc = cyc;
                words_seen++;
                if (exp_q.size() == 0) fail("unexpected_word");
                else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", out_data, mon_e);
                end
                cur_words++;
            end
            if (out_valid_wr) begin
                vwr_seen++;
                check("out_valid", out_valid, 1);
                if (len_q.size() == 0) fail("unexpected_eop");
                else begin
                    mon_l = len_q.pop_front();
                    check("pkt_len", cur_words, mon_l);
                end
                cur_words = 0;
            end
        end
    end

    int last_commit_cyc = 0;

    // Drives one packet; the first n_wr words must be written at base, base+1...
    task automatic send_pkt(input int len, input bit good, input int base,
                            input int n_wr, input bit expect_out);
        logic [133:0] w;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            w[131:0]   = {4'(i), $urandom(), $urandom(), $urandom(), $urandom()};
            w[133:132] = (i == 0) ? 2'b01 : (i == len - 1) ? 2'b10 : 2'b11;
            in_data     = w;
            in_data_wr  = 1'b1;
            in_valid_wr = (i == len - 1);
            in_valid    = (i == len - 1) ? good : 1'b0;
            if (expect_out) exp_q.push_back(w);
            @(negedge clk);
            if (i < n_wr) begin
                check("ram_wr", ram_wr, 1);
                check("ram_wr_addr", ram_wr_addr, (base + i) % DEPTH);
            end else begin
                check("ram_wr_blocked", ram_wr, 0);
            end
            last_commit_cyc = cyc;
        end
        if (expect_out) len_q.push_back(len);
        @(posedge clk); #1;
        in_data_wr  = 1'b0;
        in_valid_wr = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) fail("drain_timeout");
        repeat (3) @(posedge clk);
    endtask

    task automatic check_zero_outputs();
        check("rst_out_data", out_data, 0);
        check("rst_out_data_wr", out_data_wr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_valid_wr", out_valid_wr, 0);
        check("rst_ram_wr", ram_wr, 0);
        check("rst_ram_wr_addr", ram_wr_addr, 0);
        check("rst_ram_wr_data", ram_wr_data, 0);
        check("rst_ram_rd", ram_rd, 0);
        check("rst_ram_rd_addr", ram_rd_addr, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_stat_pkt_cnt", stat_pkt_cnt, 0);
        check("rst_stat_word_cnt", stat_word_cnt, 0);
    endtask

    task automatic check_stats();
`ifdef SSM_BUF_STAT_EN
        check("stat_pkt_cnt", stat_pkt_cnt, vwr_seen);
        check("stat_word_cnt", stat_word_cnt, words_seen);
`else
        check("stat_pkt_cnt_off", stat_pkt_cnt, 0);
        check("stat_word_cnt_off", stat_word_cnt, 0);
`endif
    endtask

    typedef struct {
        int len;
        bit good;
        int base;
        int exp_drop;
    } vec_t;

    vec_t vt [6];
    int   rd0, vw0, n;

    initial begin
        vt[0] = '{len: 4, good: 1'b0, base: 4,  exp_drop: 1};
        vt[1] = '{len: 1, good: 1'b1, base: 4,  exp_drop: 1};
        vt[2] = '{len: 7, good: 1'b1, base: 5,  exp_drop: 1};
        vt[3] = '{len: 3, good: 1'b0, base: 12, exp_drop: 2};
        vt[4] = '{len: 2, good: 1'b1, base: 12, exp_drop: 2};
        vt[5] = '{len: 5, good: 1'b0, base: 14, exp_drop: 3};

        rst = 1'b1; in_data = '0; in_data_wr = 1'b0; in_valid = 1'b0;
        in_valid_wr = 1'b0; out_alf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs();
        @(posedge clk); #1 rst = 1'b0;

        // 4-word good packet: addresses 0..3, first word 4 cycles after commit
        send_pkt(4, 1'b1, 0, 4, 1'b1);
        wait_drain(100);
        check("latency", first_cyc, last_commit_cyc + 4);
        check("eop_count", vwr_seen, 1);
        check("drop_cnt_good", drop_cnt, 0);

        // Table of good/bad packets with rollback
        for (int i = 0; i < 6; i++) begin
            send_pkt(vt[i].len, vt[i].good, vt[i].base, vt[i].len, vt[i].good);
            wait_drain(200);
            check("tbl_drop_cnt", drop_cnt, vt[i].exp_drop);
        end

        // Almost-full holds off replay; mid-packet assertion does not stall
        out_alf = 1'b1;
        rd0 = rd_seen;
        send_pkt(3, 1'b1, 14, 3, 1'b1);
        send_pkt(5, 1'b1, 17, 5, 1'b1);
        repeat (20) @(posedge clk);
        check("alf_no_rd", rd_seen - rd0, 0);
        vw0 = vwr_seen;
        @(posedge clk); #1 out_alf = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_data_wr && n < 50);
        if (n >= 50) fail("alf_release_timeout");
        out_alf = 1'b1;
        repeat (30) @(posedge clk);
        check("alf_one_pkt", vwr_seen - vw0, 1);
        check("alf_pending", len_q.size(), 1);
        out_alf = 1'b0;
        wait_drain(100);
        check("alf_both_pkts", vwr_seen - vw0, 2);

        // Fill: 2040 words held, next packet overflows at word 9
        out_alf = 1'b1;
        rd0 = rd_seen;
        for (int p = 0; p < 30; p++)
            send_pkt(68, 1'b1, (22 + 68 * p) % DEPTH, 68, 1'b1);
        send_pkt(16, 1'b1, (22 + 2040) % DEPTH, 8, 1'b0);
        check("fill_drop_cnt", drop_cnt, 4);
        check("fill_no_rd", rd_seen - rd0, 0);
        vw0 = vwr_seen;
        out_alf = 1'b0;
        wait_drain(6000);
        check("fill_replayed", vwr_seen - vw0, 30);

        // Pad to address 2046, then a packet straddling address 0
        send_pkt(2032, 1'b1, 14, 2032, 1'b1);
        wait_drain(5000);
        send_pkt(6, 1'b1, 2046, 6, 1'b1);
        wait_drain(100);

        // Descriptor FIFO full: 33rd queued packet is dropped
        out_alf = 1'b1;
        for (int p = 0; p < 32; p++) send_pkt(1, 1'b1, 4 + p, 1, 1'b1);
        send_pkt(1, 1'b1, 36, 1, 1'b0);
        check("desc_full_drop", drop_cnt, 5);
        out_alf = 1'b0;
        wait_drain(500);
        check_stats();

        // Reset in the middle of a replay
        send_pkt(10, 1'b1, 36, 10, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_data_wr && n < 50);
        if (n >= 50) fail("replay_start_timeout");
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_zero_outputs();
        exp_q.delete();
        len_q.delete();
        @(negedge clk);
        check_zero_outputs();
        @(posedge clk); #1 rst = 1'b0;
        rd0 = rd_seen;
        repeat (20) @(posedge clk);
        check("post_rst_idle", rd_seen - rd0, 0);
        send_pkt(4, 1'b1, 0, 4, 1'b1);
        wait_drain(100);
        check("post_rst_drop_cnt", drop_cnt, 0);
        check("post_rst_eop", vwr_seen, 1);
        check_stats();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
